pwm_duty_decoder: RTL and testbench
===================================

Name: pwm_duty_decoder

Overview:
Receive end of the per-device PWM brightness link. Samples NUMBER_DEVICES PWM lines over consecutive 16-clock windows and recovers each device's 4-bit brightness (0-15) as the count of high samples per window. Sits beside the LED fader in loopback/self-test builds and on boards that receive fader outputs from another FPGA over the same clock. Reports per-window valid, per-device change and over-range flags.

Parameters:
NUMBER_DEVICES, 16, number of PWM input lines / decoded channels.

Ports:
clk  input  1  system clock; pwm_in synchronous to it.
rst  input  1  asynchronous, active-high reset.
enable  input  1  decoding enable; low aborts the current window.
pwm_in  input  NUMBER_DEVICES  PWM lines; bit k = device k.
brightness  output  4*NUMBER_DEVICES  decoded level; device k at [4k+3:4k].
valid  output  1  one-cycle pulse: brightness/changed/overrange updated.
changed  output  NUMBER_DEVICES  bit k set when device k's new level differs from its previous latched level.
overrange  output  NUMBER_DEVICES  bit k set when device k was high for all 16 samples (saturated).

Behaviour:
- Reset (async, rst=1): state IDLE, window counter wcnt=0, all accumulators 0, brightness=0, valid=0, changed=0, overrange=0.
- FSM states IDLE, ARM, RUN. Registered; evaluated every rising clk.
- IDLE: enable=1 -> ARM; else stay. Accumulators and wcnt held at 0.
- ARM: exactly one cycle; clears accumulators and wcnt; -> RUN (-> IDLE if enable=0).
- RUN: each edge, acc[k] += pwm_in[k] (acc 5 bits, 0..16); wcnt += 1 (4 bits, wraps 15->0).
- Window close: edge where wcnt==15. The final result includes that edge's sample (acc[k]+pwm_in[k]). The same edge latches result into brightness[k], clears acc, wraps wcnt to 0, and sets valid=1 for the following cycle only. The next window starts with no gap.
- Saturation: result 16 -> brightness[k]=15, overrange[k]=1. Otherwise overrange[k]=0. Flags are recomputed every window.
- changed[k] = (new level != level held before this latch). It updates on the same edge as brightness and holds until the next window close. The first window after reset compares against 0.
- Latency: enable first sampled high at edge T0 -> ARM after T0. RUN from T1. The 16 samples are taken at edges T2..T17. valid is high in the cycle after T17.
- Phase independence: no sync input. Any 16 consecutive samples of a constant-duty 16-period PWM yield its duty, so the transmitter counter phase is irrelevant.
- enable=0 in RUN: -> IDLE on the next edge; partial window discarded; no valid. brightness, changed and overrange hold their last values.
- enable=0 on a window-close edge: that window still latches and valid pulses. The FSM then goes to IDLE.
- rst mid-window: immediate clear to reset values; no valid.
- valid never asserts in IDLE or ARM, and never on two consecutive cycles.

Decomposition:
- Shared package: PWM_PERIOD=16, BRIGHT_W=4, ACC_W=5, and the state encoding for IDLE/ARM/RUN.
- Sub-module pwm_duty_channel (one per device via generate): accumulator, saturation, latched level, changed/overrange. Inputs are sample, clear, close, and the pwm bit.
- Top level holds the FSM, wcnt and the valid register.

Test Plan:
- Reset then enable=1; feed each device a 16-period PWM model with level k (device k, level=k mod 16). Required: first valid exactly 17 cycles after the enable edge; brightness[4k+3:4k]=k mod 16; changed=all ones except device 0; overrange=0.
- Device 3 pwm_in held at 1: brightness=15, overrange[3]=1. Device 3 at PWM level 15: brightness=15, overrange[3]=0.
- Level 10 started at 5 different phase offsets relative to the window: every window decodes 10.
- Level on device 2 steps 6->9 mid-stream. Required: one transitional window with a level between 6 and 9; then 9 with changed[2]=1; then changed[2]=0 on the following window.
- enable dropped when wcnt=8. Required: no valid; outputs hold the previous values. Re-enable: next valid 17 cycles after the re-enable edge with correct levels.
- rst pulsed at wcnt=5 with outputs nonzero. Required: all outputs 0 immediately (asynchronous), with no valid until a full window has completed after reset.

Source files
------------

// File: rtl/pwm_duty_decoder_pkg.sv
// Shared constants, state encoding and helpers for the PWM duty decoder.
// Window length, level width and accumulator width live here.
package pwm_duty_decoder_pkg;

  localparam int PWM_PERIOD = 16;
  localparam int BRIGHT_W   = 4;
  localparam int ACC_W      = 5;
  localparam int WCNT_W     = 4;

  localparam logic [WCNT_W-1:0]   WCNT_LAST = WCNT_W'(PWM_PERIOD - 1);
  localparam logic [BRIGHT_W-1:0] LEVEL_MAX = '1;
  localparam logic [ACC_W-1:0]    ACC_FULL  = ACC_W'(PWM_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // A window that was high on every sample cannot be shown as 16 in 4 bits.
  function automatic logic [BRIGHT_W-1:0] sat_level(
    input logic [ACC_W-1:0] sum
  );
    logic [BRIGHT_W-1:0] lvl;
    if (sum >= ACC_FULL) begin
      lvl = LEVEL_MAX;
    end else begin
      lvl = sum[BRIGHT_W-1:0];
    end
    return lvl;
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_channel.sv
// One decoded PWM line: high-sample accumulator plus latched level/flags.
// The closing sample is folded in combinationally so no window edge is lost.
module pwm_duty_channel
  import pwm_duty_decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_sample,
  input  logic                i_clear,
  input  logic                i_close,
  input  logic                i_pwm,
  output logic [BRIGHT_W-1:0] o_level,
  output logic                o_changed,
  output logic                o_overrange
);

  logic [ACC_W-1:0]    r_acc;
  logic [BRIGHT_W-1:0] r_level;
  logic                r_changed;
  logic                r_overrange;

  logic [ACC_W-1:0]    w_sum;
  logic [BRIGHT_W-1:0] w_level;

  assign w_sum   = r_acc + ACC_W'(i_pwm);
  assign w_level = sat_level(w_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_close || i_clear) begin
      r_acc <= '0;
    end else if (i_sample) begin
      r_acc <= w_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level     <= '0;
      r_changed   <= 1'b0;
      r_overrange <= 1'b0;
    end else if (i_close) begin
      r_level     <= w_level;
      r_changed   <= (w_level != r_level);
      r_overrange <= (w_sum == ACC_FULL);
    end
  end

  assign o_level     = r_level;
  assign o_changed   = r_changed;
  assign o_overrange = r_overrange;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers per-device 4-bit brightness from PWM lines over 16-clock windows.
// Holds the IDLE/ARM/RUN sequencer, window counter and valid pulse.
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int NUMBER_DEVICES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUMBER_DEVICES-1:0]    pwm_in,
  output logic [BRIGHT_W*NUMBER_DEVICES-1:0] brightness,
  output logic                         valid,
  output logic [NUMBER_DEVICES-1:0]    changed,
  output logic [NUMBER_DEVICES-1:0]    overrange
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_valid;

  logic w_run;
  logic w_sample;
  logic w_close;
  logic w_clear;

  assign w_run    = (r_state == ST_RUN);
  assign w_sample = w_run && enable;
  // A closing edge still completes even if enable has just dropped.
  assign w_close  = w_run && (r_wcnt == WCNT_LAST);
  assign w_clear  = !w_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_state_nxt = enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_sample) begin
      r_wcnt <= r_wcnt + 1'b1;
    end else begin
      r_wcnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_close;
    end
  end

  assign valid = r_valid;

  for (genvar g = 0; g < NUMBER_DEVICES; g++) begin : g_ch
    pwm_duty_channel u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_sample    (w_sample),
      .i_clear     (w_clear),
      .i_close     (w_close),
      .i_pwm       (pwm_in[g]),
      .o_level     (brightness[BRIGHT_W*g +: BRIGHT_W]),
      .o_changed   (changed[g]),
      .o_overrange (overrange[g])
    );
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized bench for pwm_duty_decoder against a sample-counting model.
// Model counts enabled edges and groups samples into 16-sample windows.
module tb_pwm_duty_decoder;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   pwm_in = '0;
  logic [4*N-1:0] brightness;
  logic           valid;
  logic [N-1:0]   changed;
  logic [N-1:0]   overrange;

  pwm_duty_decoder #(.NUMBER_DEVICES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .brightness (brightness),
    .valid      (valid),
    .changed    (changed),
    .overrange  (overrange)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // transmitter side: level 16 means line stuck high
  int lvl [N];
  int ph  [N];
  int tcount = 0;

  function automatic logic [N-1:0] gen_pwm();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) begin
      if (lvl[k] >= 16) v[k] = 1'b1;
      else v[k] = (((tcount + ph[k]) % 16) < lvl[k]);
    end
    return v;
  endfunction

  // reference: m_run = consecutive enabled edges, m_n = samples in window
  int           m_run;
  int           m_n;
  int           m_cnt [N];
  int           m_br  [N];
  logic         m_valid;
  logic [N-1:0] m_chg;
  logic [N-1:0] m_ovr;

  task automatic model_reset();
    m_run = 0;
    m_n = 0;
    m_valid = 1'b0;
    m_chg = '0;
    m_ovr = '0;
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0;
      m_br[k] = 0;
    end
  endtask

  task automatic model_edge(input logic en, input logic [N-1:0] p);
    bit samp;
    int lv;
    samp = (m_run >= 2) && (en || m_n == 15);
    m_valid = 1'b0;
    if (samp) begin
      for (int k = 0; k < N; k++) m_cnt[k] += int'(p[k]);
      m_n++;
      if (m_n == 16) begin
        for (int k = 0; k < N; k++) begin
          lv = (m_cnt[k] > 15) ? 15 : m_cnt[k];
          m_chg[k] = (lv != m_br[k]);
          m_ovr[k] = (m_cnt[k] == 16);
          m_br[k] = lv;
          m_cnt[k] = 0;
        end
        m_n = 0;
        m_valid = 1'b1;
      end
    end else if (!en) begin
      m_n = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end
    if (!en) m_run = 0;
    else if (m_run < 1000) m_run++;
  endtask

  function automatic logic [4*N-1:0] m_bright();
    logic [4*N-1:0] v;
    for (int k = 0; k < N; k++) v[4*k +: 4] = 4'(m_br[k]);
    return v;
  endfunction

  task automatic step();
    pwm_in = gen_pwm();
    @(posedge clk);
    model_edge(enable, pwm_in);
    #1;
    check("valid", 64'(valid), 64'(m_valid));
    check("bright", 64'(brightness), 64'(m_bright()));
    check("changed", 64'(changed), 64'(m_chg));
    check("overrange", 64'(overrange), 64'(m_ovr));
    tcount++;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    check("rst_bright", 64'(brightness), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_changed", 64'(changed), 64'd0);
    check("rst_ovr", 64'(overrange), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int             n;
  int             nv;
  int             v0, v1, v2;
  logic           c0, c1, c2;
  logic [4*N-1:0] exp_b;
  logic [4*N-1:0] snap_b;

  initial begin
    model_reset();
    for (int k = 0; k < N; k++) begin
      lvl[k] = k % 16;
      ph[k] = 0;
    end
    #2;
    check("reset_bright", 64'(brightness), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_changed", 64'(changed), 64'd0);
    check("reset_ovr", 64'(overrange), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // levels 0..15 on devices 0..15
    enable = 1'b1;
    step();
    wait_valid(n);
    check("first_latency", 64'(n), 64'd17);
    for (int k = 0; k < N; k++) exp_b[4*k +: 4] = 4'(k % 16);
    check("first_bright", 64'(brightness), 64'(exp_b));
    check("first_changed", 64'(changed), 64'hFFFE);
    check("first_ovr", 64'(overrange), 64'd0);

    // saturation vs full-scale 15
    lvl[3] = 16;
    wait_valid(n);
    wait_valid(n);
    check("sat_wait", 64'(n < 0), 64'd0);
    check("sat_level", 64'(brightness[15:12]), 64'd15);
    check("sat_ovr", 64'(overrange[3]), 64'd1);
    lvl[3] = 15;
    wait_valid(n);
    wait_valid(n);
    check("l15_level", 64'(brightness[15:12]), 64'd15);
    check("l15_ovr", 64'(overrange[3]), 64'd0);

    // level 10 at five phase offsets
    ph[0] = 0; ph[1] = 3; ph[4] = 7; ph[5] = 11; ph[6] = 14;
    foreach (ph[k]) if (k < 7 && k != 2 && k != 3) lvl[k] = 10;
    wait_valid(n);
    for (int w = 0; w < 3; w++) begin
      wait_valid(n);
      check("ph_d0", 64'(brightness[3:0]), 64'd10);
      check("ph_d1", 64'(brightness[7:4]), 64'd10);
      check("ph_d4", 64'(brightness[19:16]), 64'd10);
      check("ph_d5", 64'(brightness[23:20]), 64'd10);
      check("ph_d6", 64'(brightness[27:24]), 64'd10);
    end

    // device 2 steps 6 -> 9 mid-window
    lvl[2] = 6;
    wait_valid(n);
    wait_valid(n);
    for (int i = 0; i < 7; i++) step();
    lvl[2] = 9;
    wait_valid(n);
    v0 = int'(brightness[11:8]); c0 = changed[2];
    wait_valid(n);
    v1 = int'(brightness[11:8]); c1 = changed[2];
    wait_valid(n);
    v2 = int'(brightness[11:8]); c2 = changed[2];
    check("step_trans", 64'(v0 >= 6 && v0 <= 9), 64'd1);
    if (v0 == 9) check("step_chg_first", 64'(c0), 64'd1);
    else begin
      check("step_new", 64'(v1), 64'd9);
      check("step_chg_new", 64'(c1), 64'd1);
    end
    check("step_settled", 64'(v2), 64'd9);
    check("step_chg_settled", 64'(c2), 64'd0);

    // enable dropped at wcnt 8
    wait_valid(n);
    for (int i = 0; i < 8; i++) step();
    snap_b = brightness;
    enable = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid) nv++;
    end
    check("drop_novalid", 64'(nv), 64'd0);
    check("drop_hold", 64'(brightness), 64'(snap_b));
    enable = 1'b1;
    step();
    wait_valid(n);
    check("reen_latency", 64'(n), 64'd17);

    // async reset mid-window at wcnt 5
    wait_valid(n);
    for (int i = 0; i < 5; i++) step();
    pulse_rst();
    step();
    wait_valid(n);
    check("rst_latency", 64'(n), 64'd17);

    // randomized levels, phases and enable drops
    for (int k = 0; k < N; k++) ph[k] = $urandom_range(0, 15);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0)
        lvl[$urandom_range(0, N - 1)] = $urandom_range(0, 16);
      if ($urandom_range(0, 299) == 0) enable = 1'b0;
      else if ($urandom_range(0, 3) == 0) enable = 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
